// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the board reset sequencer.
package reset_sequencer_pkg;
`include "reset_sequencer_defines.vh"

   typedef enum logic [2:0] {
      ST_SYNC      = `RSEQ_SYNC,
      ST_WAIT_LOCK = `RSEQ_WAIT_LOCK,
      ST_STRETCH   = `RSEQ_STRETCH,
      ST_RELEASE   = `RSEQ_RELEASE,
      ST_RUN       = `RSEQ_RUN
   } rseq_state_e;

   function automatic int cnt_width(input int a, input int b);
      return `RSEQ_CNT_W(a, b);
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Lock/soft-reset inputs and domain-reset/monitor outputs of the reset sequencer.
interface reset_sequencer_if #(
   parameter int N_DOMAINS = 4
);
   logic                 i_pll_locked;
   logic                 i_soft_rst;
   logic [N_DOMAINS-1:0] o_rst;
   logic                 o_ready;
   logic [2:0]           o_state;
   logic [7:0]           o_rst_count;

   modport slave (
      input  i_pll_locked, i_soft_rst,
      output o_rst, o_ready, o_state, o_rst_count
   );

   modport master (
      output i_pll_locked, i_soft_rst,
      input  o_rst, o_ready, o_state, o_rst_count
   );
endinterface

// File: rtl/reset_sequencer_defines.vh
// State encodings and counter-width macro shared by the reset sequencer sources.
`ifndef RESET_SEQUENCER_DEFINES_VH
`define RESET_SEQUENCER_DEFINES_VH

`define RSEQ_SYNC      3'd0
`define RSEQ_WAIT_LOCK 3'd1
`define RSEQ_STRETCH   3'd2
`define RSEQ_RELEASE   3'd3
`define RSEQ_RUN       3'd4

`define RSEQ_CNT_W(a, b) ($clog2((((a) > (b)) ? (a) : (b)) + 1))

`endif

// File: rtl/rst_sync_cell.sv
// Multi-flop synchroniser with asynchronous active-low clear; output is 0 while cleared.
module rst_sync_cell #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic clr_n_i,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) sync_q <= '0;
      else          sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: async assert, sync release, PLL-lock gating, stretch,
// staged per-domain release, soft-reset re-entry and saturating event count.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int N_DOMAINS      = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int STRETCH_CYCLES = 16,
   parameter int STAGE_GAP      = 8
) (
   input  logic             i_brd_clk,
   input  logic             i_reset_n,
   reset_sequencer_if.slave rs_if
);
   localparam int CNT_W = cnt_width(STRETCH_CYCLES, STAGE_GAP);
   localparam int IDX_W = $clog2(N_DOMAINS + 1);

   rseq_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [N_DOMAINS-1:0] rst_q, rst_d;
   logic                 ready_q, ready_d;
   logic [7:0]           evt_q, evt_d;
   logic                 rel_s, lock_s;

   rst_sync_cell #(.STAGES(SYNC_STAGES)) u_rel_sync (
      .clk_i   (i_brd_clk),
      .clr_n_i (i_reset_n),
      .d_i     (1'b1),
      .q_o     (rel_s)
   );

   rst_sync_cell #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk_i   (i_brd_clk),
      .clr_n_i (i_reset_n),
      .d_i     (rs_if.i_pll_locked),
      .q_o     (lock_s)
   );

   always_ff @(posedge i_brd_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_SYNC;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '1;
         ready_q <= 1'b0;
         evt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
         evt_q   <= evt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      evt_d   = evt_q;
      case (state_q)
         ST_SYNC: if (rel_s) state_d = ST_WAIT_LOCK;
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
            end
         end
         ST_STRETCH: begin
            if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
               rst_d[0] = 1'b0;
               cnt_d    = '0;
               idx_d    = IDX_W'(1);
               if (N_DOMAINS == 1) begin
                  state_d = ST_RUN;
                  ready_d = 1'b1;
               end else begin
                  state_d = ST_RELEASE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
               cnt_d = '0;
               idx_d = idx_q + 1'b1;
               for (int k = 0; k < N_DOMAINS; k++) begin
                  if (idx_q == IDX_W'(k)) rst_d[k] = 1'b0;
               end
               if (idx_q == IDX_W'(N_DOMAINS - 1)) begin
                  state_d = ST_RUN;
                  ready_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RUN: ;
         default: state_d = ST_SYNC;
      endcase

      // Lock loss and soft request share one re-entry path, so a coincident pair counts once.
      if ((state_q == ST_STRETCH || state_q == ST_RELEASE || state_q == ST_RUN) &&
          (!lock_s || rs_if.i_soft_rst)) begin
         state_d = ST_WAIT_LOCK;
         rst_d   = '1;
         ready_d = 1'b0;
         cnt_d   = '0;
         idx_d   = '0;
         if (evt_q != 8'hFF) evt_d = evt_q + 1'b1;
      end
   end

   assign rs_if.o_rst       = rst_q;
   assign rs_if.o_ready     = ready_q;
   assign rs_if.o_state     = state_q;
   assign rs_if.o_rst_count = evt_q;
endmodule
